// File: rtl/spi_slave_if.sv
// Bus-side signals of the SPI slave: serial pins, mode straps and the local tx/rx word port.
interface spi_slave_if #(
    parameter int unsigned Data = 8
);
    logic            sclk;
    logic            ss;
    logic            mosi;
    logic            miso;
    logic            cpol;
    logic            cpha;
    logic [Data-1:0] s_wdata;
    logic            tx_load;
    logic [Data-1:0] s_rdata;
    logic            rx_valid;
    logic            tx_full;
    logic            tx_underrun;
    logic            frame_err;
    logic            busy;

    modport master (
        output sclk, ss, mosi, cpol, cpha, s_wdata, tx_load,
        input  miso, s_rdata, rx_valid, tx_full, tx_underrun, frame_err, busy
    );

    modport slave (
        input  sclk, ss, mosi, cpol, cpha, s_wdata, tx_load,
        output miso, s_rdata, rx_valid, tx_full, tx_underrun, frame_err, busy
    );
endinterface

// File: rtl/spi_slave.sv
// Oversampling SPI slave: LSB-first, all four CPOL/CPHA modes, back-to-back frames under one ss.
module spi_slave #(
    parameter int unsigned Data       = 8,
    parameter int unsigned Counter    = 4,
    parameter int unsigned SyncStages = 2
) (
    input logic        clk,
    input logic        preset,
    spi_slave_if.slave sif
);
    typedef enum logic {StIdle, StActive} state_e;

    state_e                state_q, state_d;
    logic [SyncStages-1:0] sclk_sync_q, sclk_sync_d, ss_sync_q, ss_sync_d, mosi_sync_q, mosi_sync_d;
    logic                  sclk_prev_q, sclk_prev_d, ss_prev_q, ss_prev_d;
    logic                  cpol_q, cpol_d, cpha_q, cpha_d;
    logic [Counter-1:0]    cnt_q, cnt_d;
    logic [Data-1:0]       rx_q, rx_d, tx_q, tx_d, hold_q, hold_d, rdata_q, rdata_d;
    logic                  full_q, full_d, miso_q, miso_d, first_q, first_d, skip_q, skip_d;
    logic                  rx_done_q, rx_done_d, rx_pend_q, rx_pend_d, valid_q, valid_d;
    logic                  under_q, under_d, ur_pend_q, ur_pend_d, ferr_q, ferr_d;
    logic                  reload;

    logic sclk_s, ss_s, mosi_s, sclk_edge, lead, trail, samp, shft, ss_fall, ss_rise;

    assign sclk_s    = sclk_sync_q[SyncStages-1];
    assign ss_s      = ss_sync_q[SyncStages-1];
    assign mosi_s    = mosi_sync_q[SyncStages-1];
    assign sclk_edge = sclk_s ^ sclk_prev_q;
    assign lead      = sclk_edge & (sclk_s != cpol_q);
    assign trail     = sclk_edge & (sclk_s == cpol_q);
    assign samp      = cpha_q ? trail : lead;
    assign shft      = cpha_q ? lead : trail;
    assign ss_fall   = ss_prev_q & ~ss_s;
    assign ss_rise   = ~ss_prev_q & ss_s;

    always_comb begin
        state_d     = state_q;
        sclk_sync_d = {sclk_sync_q[SyncStages-2:0], sif.sclk};
        ss_sync_d   = {ss_sync_q[SyncStages-2:0], sif.ss};
        mosi_sync_d = {mosi_sync_q[SyncStages-2:0], sif.mosi};
        sclk_prev_d = sclk_s;
        ss_prev_d   = ss_s;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        hold_d      = hold_q;
        full_d      = full_q;
        miso_d      = miso_q;
        first_d     = first_q;
        skip_d      = skip_q;
        ur_pend_d   = ur_pend_q;
        under_d     = 1'b0;
        ferr_d      = 1'b0;
        rx_done_d   = 1'b0;
        rx_pend_d   = rx_done_q;
        valid_d     = rx_pend_q;
        rdata_d     = rx_done_q ? rx_q : rdata_q;
        reload      = 1'b0;

        unique case (state_q)
            StIdle: begin
                miso_d = 1'b0;
                if (ss_fall) begin
                    state_d   = StActive;
                    cpol_d    = sif.cpol;
                    cpha_d    = sif.cpha;
                    cnt_d     = '0;
                    first_d   = 1'b1;
                    skip_d    = 1'b0;
                    ur_pend_d = 1'b0;
                    reload    = 1'b1;
                end
            end
            StActive: begin
                if (ss_rise) begin
                    state_d   = StIdle;
                    miso_d    = 1'b0;
                    cnt_d     = '0;
                    ur_pend_d = 1'b0;
                    ferr_d    = (cnt_q != '0);
                end else begin
                    // An empty reload at frame end only counts once the next frame really begins.
                    if (lead && ur_pend_q) begin
                        under_d   = 1'b1;
                        ur_pend_d = 1'b0;
                    end
                    if (samp) begin
                        rx_d = {mosi_s, rx_q[Data-1:1]};
                        if (cnt_q == Counter'(Data - 1)) begin
                            cnt_d     = '0;
                            rx_done_d = 1'b1;
                            first_d   = 1'b1;
                            skip_d    = ~cpha_q;
                            reload    = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (shft) begin
                        if (skip_q) begin
                            skip_d = 1'b0;
                        end else if (first_q && cpha_q) begin
                            first_d = 1'b0;
                            miso_d  = tx_q[0];
                        end else begin
                            tx_d   = {1'b0, tx_q[Data-1:1]};
                            miso_d = tx_q[1];
                        end
                    end
                end
            end
        endcase

        if (reload) begin
            if (full_q) begin
                tx_d   = hold_q;
                full_d = 1'b0;
            end else begin
                tx_d = '0;
                if (state_q == StIdle) under_d = 1'b1;
                else ur_pend_d = 1'b1;
            end
            if (!cpha_d) miso_d = tx_d[0];
        end

        // A same-cycle write lands after the reload has taken the old holding value.
        if (sif.tx_load) begin
            hold_d = sif.s_wdata;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (preset) begin
            state_q     <= StIdle;
            sclk_sync_q <= {SyncStages{sif.cpol}};
            ss_sync_q   <= {SyncStages{1'b1}};
            mosi_sync_q <= '0;
            sclk_prev_q <= sif.cpol;
            ss_prev_q   <= 1'b1;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            hold_q      <= '0;
            rdata_q     <= '0;
            full_q      <= 1'b0;
            miso_q      <= 1'b0;
            first_q     <= 1'b0;
            skip_q      <= 1'b0;
            rx_done_q   <= 1'b0;
            rx_pend_q   <= 1'b0;
            valid_q     <= 1'b0;
            under_q     <= 1'b0;
            ur_pend_q   <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            ss_prev_q   <= ss_prev_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            hold_q      <= hold_d;
            rdata_q     <= rdata_d;
            full_q      <= full_d;
            miso_q      <= miso_d;
            first_q     <= first_d;
            skip_q      <= skip_d;
            rx_done_q   <= rx_done_d;
            rx_pend_q   <= rx_pend_d;
            valid_q     <= valid_d;
            under_q     <= under_d;
            ur_pend_q   <= ur_pend_d;
            ferr_q      <= ferr_d;
        end
    end

    assign sif.miso        = miso_q;
    assign sif.s_rdata     = rdata_q;
    assign sif.rx_valid    = valid_q;
    assign sif.tx_full     = full_q;
    assign sif.tx_underrun = under_q;
    assign sif.frame_err   = ferr_q;
    assign sif.busy        = (state_q == StActive);
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: an SPI master model drives sessions; a transaction-level model predicts words.
module tb_spi_slave;
    localparam int unsigned S = 2;

    logic clk = 1'b0;
    logic preset;
    always #5 clk = ~clk;

    spi_slave_if #(.Data(8)) sif ();

    spi_slave #(.Data(8), .Counter(4), .SyncStages(S)) dut (
        .clk   (clk),
        .preset(preset),
        .sif   (sif)
    );

    int n_cmp = 0, n_fail = 0;
    int n_rv = 0, n_ur = 0, n_fe = 0;
    int exp_rv = 0, exp_ur = 0, exp_fe = 0;
    logic [7:0] exp_rdata = 8'h00;
    logic [7:0] hold_m = 8'h00;
    logic       full_m = 1'b0;
    logic [7:0] mo_b [4];
    logic [7:0] mi_b [4];
    logic [7:0] ex_b [5];
    time samp_t = 0, rv_t = 0;

    always @(negedge clk) begin
        if (sif.rx_valid) n_rv++;
        if (sif.tx_underrun) n_ur++;
        if (sif.frame_err) n_fe++;
    end
    always @(posedge sif.rx_valid) rv_t = $time;

    task automatic chk(input string tag, input string what, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", tag, what, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Holding register is consumed at every frame start and at every frame completion.
    task automatic take(output logic [7:0] w, output logic empty);
        empty  = !full_m;
        w      = full_m ? hold_m : 8'h00;
        full_m = 1'b0;
    endtask

    task automatic load(input logic [7:0] w);
        @(negedge clk);
        sif.s_wdata = w;
        sif.tx_load = 1'b1;
        @(negedge clk);
        sif.tx_load = 1'b0;
        hold_m = w;
        full_m = 1'b1;
    endtask

    task automatic set_mode(input logic cp, input logic ch);
        @(negedge clk);
        sif.cpol = cp;
        sif.cpha = ch;
        sif.sclk = cp;
        cycles(6);
    endtask

    // Master side: sample miso on the master's sampling edge, LSB first.
    task automatic xfer(input logic [7:0] tx, input int nbits, input int hp,
                        output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!sif.cpha) begin
                sif.mosi = tx[i];
                cycles(hp);
                rx[i]    = sif.miso;
                sif.sclk = ~sif.cpol;
                samp_t   = $time;
                cycles(hp);
                sif.sclk = sif.cpol;
            end else begin
                cycles(hp);
                sif.sclk = ~sif.cpol;
                sif.mosi = tx[i];
                cycles(hp);
                rx[i]    = sif.miso;
                sif.sclk = sif.cpol;
                samp_t   = $time;
            end
        end
    endtask

    task automatic session(input int nfr, input int hp, input int nb_last, input bit rst_abort,
                           input string tag);
        logic empty;
        int   nb;
        @(negedge clk);
        sif.mosi = mo_b[0][0];
        sif.ss   = 1'b0;
        take(ex_b[0], empty);
        if (empty) exp_ur++;
        cycles(4);
        chk(tag, "busy_active", 32'(sif.busy), 32'd1);
        chk(tag, "tx_full_start", 32'(sif.tx_full), 32'(full_m));
        for (int k = 0; k < nfr; k++) begin
            nb = (k == nfr - 1) ? nb_last : 8;
            xfer(mo_b[k], nb, hp, mi_b[k]);
            if (nb == 8) begin
                exp_rv++;
                exp_rdata = mo_b[k];
                take(ex_b[k+1], empty);
                if (empty && (k + 1 < nfr)) exp_ur++;
            end else if (!rst_abort) begin
                exp_fe++;
            end
        end
        if (rst_abort) begin
            preset = 1'b1;
            cycles(1);
            chk(tag, "rst_flags", 32'({sif.miso, sif.rx_valid, sif.tx_full, sif.tx_underrun,
                                       sif.frame_err, sif.busy}), 32'd0);
            chk(tag, "rst_rdata", 32'(sif.s_rdata), 32'd0);
            preset    = 1'b0;
            sif.ss    = 1'b1;
            sif.sclk  = sif.cpol;
            hold_m    = 8'h00;
            full_m    = 1'b0;
            exp_rdata = 8'h00;
        end else begin
            cycles(hp);
            sif.ss = 1'b1;
        end
        cycles(8);
        chk(tag, "rx_valid_cnt", 32'(n_rv), 32'(exp_rv));
        chk(tag, "underrun_cnt", 32'(n_ur), 32'(exp_ur));
        chk(tag, "frame_err_cnt", 32'(n_fe), 32'(exp_fe));
        chk(tag, "s_rdata", 32'(sif.s_rdata), 32'(exp_rdata));
        chk(tag, "busy_idle", 32'({sif.busy, sif.miso}), 32'd0);
        for (int k = 0; k < nfr; k++) begin
            if (k < nfr - 1 || nb_last == 8) chk(tag, "miso_byte", 32'(mi_b[k]), 32'(ex_b[k]));
        end
        if (nb_last == 8 && !rst_abort)
            chk(tag, "rx_latency", 32'(rv_t - samp_t), 32'((S + 2) * 10 + 5));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        preset = 1'b1;
        sif.sclk = 1'b0; sif.ss = 1'b1; sif.mosi = 1'b0;
        sif.cpol = 1'b0; sif.cpha = 1'b0; sif.s_wdata = 8'h00; sif.tx_load = 1'b0;
        cycles(3);
        chk("reset", "flags", 32'({sif.miso, sif.rx_valid, sif.tx_full, sif.tx_underrun,
                                  sif.frame_err, sif.busy}), 32'd0);
        chk("reset", "s_rdata", 32'(sif.s_rdata), 32'd0);
        preset = 1'b0;
        cycles(2);

        // Mode 0 basic frame
        load(8'h3C);
        chk("mode0", "tx_full_loaded", 32'(sif.tx_full), 32'd1);
        set_mode(1'b0, 1'b0);
        mo_b[0] = 8'hA5;
        session(1, 3, 8, 1'b0, "mode0");
        chk("mode0", "miso_const", 32'(mi_b[0]), 32'h3C);
        chk("mode0", "rdata_const", 32'(sif.s_rdata), 32'hA5);

        // Modes 1..3
        for (int m = 1; m < 4; m++) begin
            load(8'h3C);
            set_mode(m[1], m[0]);
            mo_b[0] = 8'hA5;
            session(1, 3, 8, 1'b0, "modes");
            chk("modes", "miso_const", 32'(mi_b[0]), 32'h3C);
        end

        // Back-to-back, second frame underruns
        load(8'h96);
        set_mode(1'b0, 1'b0);
        mo_b[0] = 8'h01; mo_b[1] = 8'hFE;
        session(2, 4, 8, 1'b0, "b2b");
        chk("b2b", "miso2_const", 32'(mi_b[1]), 32'h00);
        chk("b2b", "rdata_const", 32'(sif.s_rdata), 32'hFE);

        // Truncated frame
        set_mode(1'b1, 1'b1);
        mo_b[0] = 8'hFF;
        session(1, 3, 5, 1'b0, "ferr");
        chk("ferr", "rdata_held", 32'(sif.s_rdata), 32'hFE);

        // Reset in the middle of a frame, then a clean frame
        load(8'h77);
        set_mode(1'b0, 1'b0);
        mo_b[0] = 8'hC3;
        session(1, 3, 3, 1'b1, "rst_mid");
        cycles(4);
        mo_b[0] = 8'h5A;
        session(1, 3, 8, 1'b0, "post_rst");
        chk("post_rst", "rdata_const", 32'(sif.s_rdata), 32'h5A);

        // Overwrite holding register before a frame
        load(8'h11);
        chk("dbl", "tx_full_1", 32'(sif.tx_full), 32'd1);
        load(8'h22);
        chk("dbl", "tx_full_2", 32'(sif.tx_full), 32'd1);
        set_mode(1'b1, 1'b0);
        mo_b[0] = 8'h3E;
        session(1, 5, 8, 1'b0, "dbl");
        chk("dbl", "miso_const", 32'(mi_b[0]), 32'h22);

        // Randomised sessions
        for (int r = 0; r < 8; r++) begin
            int nfr;
            set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) load(8'($urandom_range(0, 255)));
            nfr = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) mo_b[k] = 8'($urandom_range(0, 255));
            session(nfr, $urandom_range(3, 6), 8, 1'b0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- Receive-side SPI peer for the SPI master's serial interface. It consumes sclk, ss and mosi, and drives miso.
- All serial inputs are oversampled on the system clock. The block deserialises each frame into a parallel word and serialises a preloaded transmit word back to the master.
- It supports all four CPOL/CPHA modes. Bit order is LSB-first, to match the master's shift direction.

Parameters:
- data, 8, frame and word width in bits.
- counter, 4, bit-counter width; must satisfy 2^counter > data.
- sync_stages, 2, synchroniser depth for sclk, ss and mosi (minimum 2).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- preset  input  1  reset, synchronous, active-high.
- sclk  input  1  serial clock from master, asynchronous to clk.
- ss  input  1  slave select, active-low, asynchronous.
- mosi  input  1  serial data from master.
- cpol  input  1  clock polarity; sampled at frame start.
- cpha  input  1  clock phase; sampled at frame start.
- s_wdata  input  data  next word to transmit.
- tx_load  input  1  one-cycle strobe; writes s_wdata into the tx holding register.
- miso  output  1  serial data to master.
- s_rdata  output  data  last complete received word.
- rx_valid  output  1  one-cycle pulse when s_rdata updates.
- tx_full  output  1  tx holding register occupied.
- tx_underrun  output  1  one-cycle pulse: a frame started with the holding register empty.
- frame_err  output  1  one-cycle pulse: ss deasserted mid-frame.
- busy  output  1  high while in the ACTIVE state.

Behaviour:
- Reset (preset=1 at a clk edge): all outputs 0, synchroniser flops load idle values (ss=1, sclk=cpol), state=IDLE, bit count=0, tx holding register=0. A reset mid-frame aborts the frame with no rx_valid and no frame_err.
- Synchronisation: sclk, ss and mosi each pass through sync_stages flops. Edge detection compares the last synchroniser stage against one further flop. Legal sclk half-period is at least 3 clk cycles; slower is always legal.
- Edge naming: leading edge is the transition away from cpol_latched; trailing edge is the transition back to it. cpha=0 samples on leading and shifts on trailing. cpha=1 shifts on leading and samples on trailing.
- IDLE -> ACTIVE on a synchronised ss falling edge. In the same cycle:
  - latch cpol and cpha;
  - clear the bit count;
  - load the tx shift register from the holding register if tx_full, then clear tx_full;
  - otherwise load 0 and pulse tx_underrun.
- miso timing: with cpha=0, miso = shift[0] immediately. With cpha=1, miso is driven on the first leading edge.
- ACTIVE, sampling edge: shift the synchronised mosi into the rx register MSB-side (LSB-first reconstruction), then increment the bit count.
- ACTIVE, shifting edge: right-shift the tx register and set miso = new shift[0]. For cpha=0, skip the shift on the trailing edge that follows the final sample.
- Frame complete (bit count reaches data on a sampling edge):
  - s_rdata <= assembled word; rx_valid pulses on the next cycle;
  - bit count resets; the tx register reloads from the holding register under the same underrun rule;
  - the block stays ACTIVE, so back-to-back frames are supported while ss stays low.
- ss rises while ACTIVE:
  - bit count = 0: return to IDLE silently;
  - bit count nonzero: discard partial bits, pulse frame_err, return to IDLE;
  - in both cases s_rdata holds its value.
- IDLE: miso=0, sclk edges ignored.
- tx_load when tx_full=1: overwrite the holding register (last write wins); tx_full stays 1.
- tx_load in the same cycle as a frame-start reload: the reload consumes the old holding value (or underruns if empty), then s_wdata is stored and tx_full=1.
- rx_valid latency: exactly sync_stages+2 clk cycles after the clk edge at which the final sampling sclk edge is first registered.

Test Plan:
- Mode 0 (cpol=0, cpha=0), tx_load 8'h3C, master sends 8'hA5 -> rx_valid one cycle, s_rdata=8'hA5; miso bits observed on master sampling edges = 0,0,1,1,1,1,0,0; tx_full 1->0 at frame start.
- Modes 1/2/3 with the same data, sclk half-period = 3 clk -> s_rdata=8'hA5 and miso stream correct in each mode.
- Two back-to-back frames (8'h01, 8'hFE) under one ss low, holding register empty for the second -> two rx_valid pulses, s_rdata ends 8'hFE, one tx_underrun pulse, second miso byte all zeros.
- ss raised after 5 bits of 8'hFF -> frame_err one pulse, no rx_valid, s_rdata unchanged, busy=0.
- preset asserted mid-frame after 3 bits -> all outputs 0 next cycle; a following full frame 8'h5A is received correctly.
- tx_load 8'h11 then 8'h22 before a frame -> tx_full=1 throughout; miso transmits 8'h22.
